alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL use one clock and asynchronous active-low reset, ports in this order:
  clk  input  1  rising-edge clock
  reset_n  input  1  asynchronous, active-low reset
REQ-002 Decode side SHALL be: instr_in input [0:31] instruction word; in_valid input 1 instruction offered; in_ready output 1 stage can accept.
REQ-003 Register-file read side SHALL be: rf_ra_addr output [0:4] = instr_in[11:15]; rf_rb_addr output [0:4] = instr_in[16:20] (both combinational); rf_ra_data, rf_rb_data input [0:63] same-cycle read data.
REQ-004 Writeback bypass SHALL be: wb_en input 1; wb_addr input [0:4]; wb_data input [0:63]; wb_ppp input [0:2] participation field of the writing instruction.
REQ-005 Control SHALL be: flush input 1, synchronous discard of all held and incoming instructions.
REQ-006 ALU side SHALL be: out_valid output 1; out_ready input 1; rA_64bit_val, rB_64bit_val output [0:63]; Op_code output [0:5]; R_ins output [0:5]; WW output [0:1]; rD_addr output [0:4]; PPP output [0:2]; all driven from the head buffer entry.

Function
REQ-007 Fields SHALL decode as Op_code=[0:5], rD=[6:10], rA=[11:15], rB=[16:20], PPP=[21:23], WW=[24:25], R_ins=[26:31]; all opcodes pass through unmodified.
REQ-008 The block SHALL hold a 2-entry in-order FIFO; count register 0..2.
REQ-009 in_ready SHALL equal (count<2), derived from registered state only, never from out_ready.
REQ-010 Push SHALL occur on a rising edge with in_valid && in_ready && !flush; pop SHALL occur with out_valid && out_ready && !flush.
REQ-011 out_valid SHALL equal (count>0); an instruction pushed into an empty FIFO at edge N SHALL be presented with out_valid=1 from edge N (one-cycle latency).
REQ-012 Simultaneous push and pop at count=1 SHALL leave count=1 with the new instruction at head; at count=2 no push is possible.
REQ-013 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-014 Bypass lane mask from wb_ppp SHALL be: 000 all bytes; 001 bits [0:31]; 010 bits [32:63]; 011 bytes 0,2,4,6; 100 bytes 1,3,5,7; 101-111 no bytes.
REQ-015 At push, if wb_en and wb_addr equals the rA (rB) field, masked lanes of the captured operand SHALL take wb_data and unmasked lanes rf data; rA and rB are bypassed independently.
REQ-016 Each cycle with wb_en, every valid held entry whose stored rA (rB) address equals wb_addr SHALL have masked lanes of that operand overwritten with wb_data.
REQ-017 Register address 0 SHALL be bypassed like any other register.
REQ-018 flush SHALL set count to 0 at the next edge, take priority over push and pop, and leave data registers unchanged.

Reset
REQ-019 While reset_n=0: count=0, out_valid=0, in_ready=1, all data outputs and buffer contents 0.
REQ-020 Reset asserted mid-operation SHALL immediately discard all entries, independent of clk.
REQ-021 First push SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-022 Empty, out_ready=1, push VADD (Op_code 101010, R_ins 000110, WW 10), rf_ra_data=64'd5, rf_rb_data=64'd10 -> next cycle out_valid=1, rA_64bit_val=5, rB_64bit_val=10, WW=10, count returns 0 after pop.
REQ-023 out_ready=0, push three instructions back-to-back -> in_ready=0 after second push, third held off; release out_ready -> outputs emerge in push order, none lost or duplicated.
REQ-024 Push with rA=3, rf_ra_data=0, same-cycle wb_en=1, wb_addr=3, wb_data=64'hFFFFFFFF_FFFFFFFF, wb_ppp=001 -> rA_64bit_val=64'hFFFFFFFF_00000000.
REQ-025 Entry held (out_ready=0) with rB=7, rB value 64'h0; then wb_en=1, wb_addr=7, wb_data=64'h1122334455667788, wb_ppp=100 -> rB_64bit_val=64'h0022004400660088.
REQ-026 count=2, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered instruction not captured.
REQ-027 count=2, pulse reset_n low between clock edges -> out_valid=0 and outputs 0 immediately, in_ready=1.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ALU operand stage: 2-entry in-order operand buffer between decode and ALU
// with byte-lane writeback bypass on capture and while entries are held.
module alu_operand_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [0:31] instr_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [0:4]  rf_ra_addr,
    output logic [0:4]  rf_rb_addr,
    input  logic [0:63] rf_ra_data,
    input  logic [0:63] rf_rb_data,
    input  logic        wb_en,
    input  logic [0:4]  wb_addr,
    input  logic [0:63] wb_data,
    input  logic [0:2]  wb_ppp,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] rA_64bit_val,
    output logic [0:63] rB_64bit_val,
    output logic [0:5]  Op_code,
    output logic [0:5]  R_ins,
    output logic [0:1]  WW,
    output logic [0:4]  rD_addr,
    output logic [0:2]  PPP
);

    typedef struct packed {
        logic [0:5]  op;
        logic [0:4]  rd;
        logic [0:4]  ra;
        logic [0:4]  rb;
        logic [0:2]  ppp;
        logic [0:1]  ww;
        logic [0:5]  rins;
        logic [0:63] a;
        logic [0:63] b;
    } entry_t;

    entry_t      ent_q [2];
    entry_t      ent_d [2];
    entry_t      upd   [2];
    entry_t      new_e;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [1:0]  count_mid;
    logic [0:63] wb_mask;
    logic        push;
    logic        pop;

    function automatic logic [0:63] lane_mask(input logic [0:2] p);
        logic [0:63] m;
        m = '0;
        case (p)
            3'b000: m = '1;
            3'b001: m[0:31] = '1;
            3'b010: m[32:63] = '1;
            3'b011: for (int k = 0; k < 8; k += 2) m[8*k +: 8] = '1;
            3'b100: for (int k = 1; k < 8; k += 2) m[8*k +: 8] = '1;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [0:63] merge(
        input logic [0:63] old,
        input logic [0:63] nw,
        input logic [0:63] m
    );
        return (old & ~m) | (nw & m);
    endfunction

    assign wb_mask    = lane_mask(wb_ppp);
    assign rf_ra_addr = instr_in[11:15];
    assign rf_rb_addr = instr_in[16:20];
    assign in_ready   = (count_q < 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign push       = in_valid && in_ready && !flush;
    assign pop        = out_valid && out_ready && !flush;

    always_comb begin
        new_e.op   = instr_in[0:5];
        new_e.rd   = instr_in[6:10];
        new_e.ra   = instr_in[11:15];
        new_e.rb   = instr_in[16:20];
        new_e.ppp  = instr_in[21:23];
        new_e.ww   = instr_in[24:25];
        new_e.rins = instr_in[26:31];
        new_e.a    = rf_ra_data;
        new_e.b    = rf_rb_data;
        if (wb_en && (wb_addr == instr_in[11:15]))
            new_e.a = merge(rf_ra_data, wb_data, wb_mask);
        if (wb_en && (wb_addr == instr_in[16:20]))
            new_e.b = merge(rf_rb_data, wb_data, wb_mask);
    end

    // Held entries snoop the writeback port every cycle
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            upd[i] = ent_q[i];
            if (wb_en && (2'(i) < count_q)) begin
                if (ent_q[i].ra == wb_addr)
                    upd[i].a = merge(ent_q[i].a, wb_data, wb_mask);
                if (ent_q[i].rb == wb_addr)
                    upd[i].b = merge(ent_q[i].b, wb_data, wb_mask);
            end
        end
    end

    always_comb begin
        ent_d     = upd;
        count_d   = count_q;
        count_mid = count_q;
        if (flush) begin
            ent_d   = ent_q;
            count_d = 2'd0;
        end else begin
            if (pop) begin
                ent_d[0]  = upd[1];
                count_mid = count_q - 2'd1;
            end
            if (push)
                ent_d[count_mid[0]] = new_e;
            count_d = count_mid + {1'b0, push};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= 2'd0;
            ent_q[0] <= '0;
            ent_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
        end
    end

    assign rA_64bit_val = ent_q[0].a;
    assign rB_64bit_val = ent_q[0].b;
    assign Op_code      = ent_q[0].op;
    assign R_ins        = ent_q[0].rins;
    assign WW           = ent_q[0].ww;
    assign rD_addr      = ent_q[0].rd;
    assign PPP          = ent_q[0].ppp;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rf_ra_addr;
    logic [4:0]  rf_rb_addr;
    logic [63:0] rf_ra_data;
    logic [63:0] rf_rb_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic [2:0]  wb_ppp;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] rA_val;
    logic [63:0] rB_val;
    logic [5:0]  Op_code;
    logic [5:0]  R_ins;
    logic [1:0]  WW;
    logic [4:0]  rD_addr;
    logic [2:0]  PPP;

    int n_pass  = 0;
    int n_total = 0;

    alu_operand_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr_in     (instr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rf_ra_addr   (rf_ra_addr),
        .rf_rb_addr   (rf_rb_addr),
        .rf_ra_data   (rf_ra_data),
        .rf_rb_data   (rf_rb_data),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_ppp       (wb_ppp),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rA_64bit_val (rA_val),
        .rB_64bit_val (rB_val),
        .Op_code      (Op_code),
        .R_ins        (R_ins),
        .WW           (WW),
        .rD_addr      (rD_addr),
        .PPP          (PPP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] a;
        logic [63:0] b;
    } ment_t;

    ment_t q[$];

    typedef struct {
        logic [31:0] instr;
        logic [63:0] rfa;
        logic [63:0] rfb;
        bit          wen;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [2:0]  ppp;
        logic [63:0] ea;
        logic [63:0] eb;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(
        input logic [5:0] op, input logic [4:0] rd, input logic [4:0] ra,
        input logic [4:0] rb, input logic [2:0] pp, input logic [1:0] ww,
        input logic [5:0] ri
    );
        return {op, rd, ra, rb, pp, ww, ri};
    endfunction

    // Byte 0 is the most significant byte of the 64-bit value
    function automatic logic [63:0] bmask(input logic [2:0] p);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            bit sel;
            case (p)
                3'd0:    sel = 1'b1;
                3'd1:    sel = (b < 4);
                3'd2:    sel = (b >= 4);
                3'd3:    sel = (b % 2 == 0);
                3'd4:    sel = (b % 2 == 1);
                default: sel = 1'b0;
            endcase
            if (sel) m[63-8*b -: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("rA_val", rA_val, q[0].a);
            chk("rB_val", rB_val, q[0].b);
            chk("Op_code", Op_code, q[0].instr[31:26]);
            chk("rD_addr", rD_addr, q[0].instr[25:21]);
            chk("PPP", PPP, q[0].instr[10:8]);
            chk("WW", WW, q[0].instr[7:6]);
            chk("R_ins", R_ins, q[0].instr[5:0]);
        end
    endtask

    task automatic step();
        logic [63:0] m;
        bit          do_pop;
        bit          do_push;
        ment_t       e;
        chk("rf_ra_addr", rf_ra_addr, instr[20:16]);
        chk("rf_rb_addr", rf_rb_addr, instr[15:11]);
        m = bmask(wb_ppp);
        if (flush) begin
            q.delete();
        end else begin
            do_push = in_valid && (q.size() < 2);
            do_pop  = out_ready && (q.size() > 0);
            if (wb_en) begin
                for (int i = 0; i < q.size(); i++) begin
                    e = q[i];
                    if (e.instr[20:16] == wb_addr) e.a = (e.a & ~m) | (wb_data & m);
                    if (e.instr[15:11] == wb_addr) e.b = (e.b & ~m) | (wb_data & m);
                    q[i] = e;
                end
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.instr = instr;
                e.a = rf_ra_data;
                e.b = rf_rb_data;
                if (wb_en && instr[20:16] == wb_addr) e.a = (e.a & ~m) | (wb_data & m);
                if (wb_en && instr[15:11] == wb_addr) e.b = (e.b & ~m) | (wb_data & m);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        wb_en    = 1'b0;
        flush    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 64'd0;
        wb_ppp   = 3'd0;
    endtask

    initial begin
        reset_n    = 1'b0;
        instr      = '0;
        rf_ra_data = '0;
        rf_rb_data = '0;
        out_ready  = 1'b0;
        idle_inputs();

        tbl[0] = '{mk(6'b101010, 5'd1, 5'd2, 5'd3, 3'd0, 2'b10, 6'b000110),
                   64'd5, 64'd10, 1'b0, 5'd0, 64'd0, 3'd0, 64'd5, 64'd10};
        tbl[1] = '{mk(6'd1, 5'd1, 5'd3, 5'd4, 3'd1, 2'b01, 6'd1),
                   64'd0, 64'h1234, 1'b1, 5'd3, 64'hFFFFFFFF_FFFFFFFF, 3'd1,
                   64'hFFFFFFFF_00000000, 64'h1234};
        tbl[2] = '{mk(6'd2, 5'd2, 5'd5, 5'd5, 3'd2, 2'b00, 6'd2),
                   64'd0, 64'd0, 1'b1, 5'd5, 64'h11223344_55667788, 3'd2,
                   64'h00000000_55667788, 64'h00000000_55667788};
        tbl[3] = '{mk(6'd3, 5'd3, 5'd6, 5'd9, 3'd3, 2'b11, 6'd3),
                   64'd0, 64'd7, 1'b1, 5'd6, 64'h11223344_55667788, 3'd3,
                   64'h11003300_55007700, 64'd7};
        tbl[4] = '{mk(6'd4, 5'd4, 5'd1, 5'd0, 3'd4, 2'b10, 6'd4),
                   64'd3, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 5'd0, 64'd0, 3'd4,
                   64'd3, 64'hFF00FF00_FF00FF00};
        tbl[5] = '{mk(6'd5, 5'd5, 5'd2, 5'd3, 3'd5, 2'b01, 6'd5),
                   64'hAA, 64'hBB, 1'b1, 5'd2, 64'hFFFFFFFF_FFFFFFFF, 3'd5,
                   64'hAA, 64'hBB};
        tbl[6] = '{mk(6'd6, 5'd6, 5'd4, 5'd4, 3'd6, 2'b00, 6'd6),
                   64'd1, 64'd2, 1'b1, 5'd4, 64'hDEADBEEF, 3'd0,
                   64'hDEADBEEF, 64'hDEADBEEF};
        tbl[7] = '{mk(6'd7, 5'd7, 5'd8, 5'd8, 3'd7, 2'b11, 6'd7),
                   64'h42, 64'h43, 1'b0, 5'd8, 64'hFFFFFFFF_FFFFFFFF, 3'd0,
                   64'h42, 64'h43};

        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rA", rA_val, 64'd0);
        chk("rst_rB", rB_val, 64'd0);
        chk("rst_op", Op_code, 6'd0);
        chk("rst_ww", WW, 2'd0);
        reset_n = 1'b1;

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr      = tbl[i].instr;
            rf_ra_data = tbl[i].rfa;
            rf_rb_data = tbl[i].rfb;
            wb_en      = tbl[i].wen;
            wb_addr    = tbl[i].waddr;
            wb_data    = tbl[i].wdata;
            wb_ppp     = tbl[i].ppp;
            in_valid   = 1'b1;
            step();
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_rA", i), rA_val, tbl[i].ea);
            chk($sformatf("vec%0d_rB", i), rB_val, tbl[i].eb);
            chk($sformatf("vec%0d_op", i), Op_code, tbl[i].instr[31:26]);
            idle_inputs();
            step();
            chk($sformatf("vec%0d_drained", i), out_valid, 1'b0);
        end

        // Back-pressure: three pushes, only two fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr = mk(6'd11, 5'd1, 5'd1, 5'd2, 3'd0, 2'd0, 6'd0);
        rf_ra_data = 64'h111; rf_rb_data = 64'h112;
        step();
        instr = mk(6'd12, 5'd2, 5'd3, 5'd4, 3'd0, 2'd1, 6'd1);
        rf_ra_data = 64'h221; rf_rb_data = 64'h222;
        step();
        chk("full_in_ready", in_ready, 1'b0);
        instr = mk(6'd13, 5'd3, 5'd5, 5'd6, 3'd0, 2'd2, 6'd2);
        rf_ra_data = 64'h331; rf_rb_data = 64'h332;
        step();
        chk("held_head_op", Op_code, 6'd11);
        chk("held_head_rA", rA_val, 64'h111);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("order_second_op", Op_code, 6'd12);
        chk("order_second_rA", rA_val, 64'h221);
        step();
        chk("third_not_captured", out_valid, 1'b0);

        // Held entry snoops a writeback with odd-byte lanes
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr = mk(6'd20, 5'd1, 5'd2, 5'd7, 3'd0, 2'd0, 6'd0);
        rf_ra_data = 64'h5; rf_rb_data = 64'h0;
        step();
        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd7;
        wb_data = 64'h11223344_55667788; wb_ppp = 3'd4;
        step();
        chk("held_bypass_rB", rB_val, 64'h00220044_00660088);
        chk("held_bypass_rA", rA_val, 64'h5);
        idle_inputs();

        // Fill to two, then flush with an offered instruction
        in_valid = 1'b1;
        instr = mk(6'd21, 5'd2, 5'd3, 5'd4, 3'd0, 2'd0, 6'd0);
        step();
        chk("flush_pre_full", in_ready, 1'b0);
        flush = 1'b1;
        instr = mk(6'd22, 5'd3, 5'd4, 5'd5, 3'd0, 2'd0, 6'd0);
        step();
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        idle_inputs();
        step();
        chk("flush_not_captured", out_valid, 1'b0);

        // Asynchronous reset pulse between edges while full
        in_valid = 1'b1;
        instr = mk(6'd30, 5'd1, 5'd1, 5'd1, 3'd1, 2'd1, 6'd1);
        rf_ra_data = 64'hABCD; rf_rb_data = 64'hDCBA;
        step();
        step();
        chk("pre_reset_full", in_ready, 1'b0);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_ready", in_ready, 1'b1);
        chk("async_rst_rA", rA_val, 64'd0);
        chk("async_rst_rB", rB_val, 64'd0);
        chk("async_rst_op", Op_code, 6'd0);
        q.delete();
        #1 reset_n = 1'b1;
        in_valid = 1'b1;
        instr = mk(6'd31, 5'd2, 5'd2, 5'd2, 3'd2, 2'd2, 6'd2);
        step();
        chk("first_push_after_rst", out_valid, 1'b1);
        chk("first_push_op", Op_code, 6'd31);

        for (int n = 0; n < 400; n++) begin
            instr          = $urandom;
            instr[20:16]   = 5'($urandom_range(0, 7));
            instr[15:11]   = 5'($urandom_range(0, 7));
            rf_ra_data     = {$urandom, $urandom};
            rf_rb_data     = {$urandom, $urandom};
            in_valid       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            wb_en          = $urandom_range(0, 1) == 1;
            wb_addr        = 5'($urandom_range(0, 7));
            wb_data        = {$urandom, $urandom};
            wb_ppp         = 3'($urandom_range(0, 7));
            flush          = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
